// File: rtl/fixmul_seq10.sv
// rtl/fixmul_seq10.sv - sequential shift-add unsigned Q5.5 multiplier
module fixmul_seq10 #(
  parameter int W    = 10,
  parameter int FRAC = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] P,
  output logic         busy,
  output logic         valid,
  output logic         ovf
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    p_q, p_d;
  logic            ovf_q, ovf_d;

  logic [2*W-1:0]  acc_sum;
  logic [2*W-1:0]  prod_shr;
  logic            last_iter;

  // Partial-product sum for this iteration; on the final iteration it is the full product.
  always_comb begin
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod_shr  = acc_sum >> FRAC;
    last_iter = (cnt_q == CW'(W - 1));
  end

  // Controller next-state and datapath next-values; P/ovf only move on the CALC->DONE step.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{W{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          // Anything above the Q5.5 integer field saturates the result.
          if (|prod_shr[2*W-1:W]) begin
            ovf_d = 1'b1;
            p_d   = '1;
          end else begin
            ovf_d = 1'b0;
            p_d   = prod_shr[W-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      ovf_q    <= ovf_d;
    end
  end

  // Status outputs decode directly from the controller state.
  always_comb begin
    busy  = (state_q == S_CALC);
    valid = (state_q == S_DONE);
    P     = p_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_fixmul_seq10.sv
// tb/tb_fixmul_seq10.sv - directed and random checks for fixmul_seq10
module tb_fixmul_seq10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] A;
  logic [9:0] B;
  logic [9:0] P;
  logic       busy;
  logic       valid;
  logic       ovf;

  int checks;
  int failures;

  fixmul_seq10 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .valid (valid),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one multiply from IDLE at a negedge and check latency, busy length, result and single pulse.
  task automatic run_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] exp_p, input logic exp_ovf);
    int n;
    int busy_cnt;
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!valid && n < 30) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 11);
    check({tag, "_busy_cycles"}, busy_cnt, 10);
    check({tag, "_P"}, P, exp_p);
    check({tag, "_ovf"}, ovf, exp_ovf);
    @(negedge clk);
    check({tag, "_single_pulse"}, valid, 0);
  endtask

  function automatic logic [10:0] model(input logic [9:0] a, input logic [9:0] b);
    logic [31:0] q;
    q = (32'(a) * 32'(b)) >> 5;
    if (q > 32'd1023) return {1'b1, 10'h3FF};
    return {1'b0, q[9:0]};
  endfunction

  initial begin
    int vcount;
    int t[3];
    int k;
    logic [10:0] m;
    logic [9:0] ra, rb;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    check("reset_P", P, 0);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_1p5x2", 10'h030, 10'h040, 10'h060, 1'b0);
    run_op("ovf_31x2", 10'h3E0, 10'h040, 10'h3FF, 1'b1);
    run_op("max_x1", 10'h3FF, 10'h020, 10'h3FF, 1'b0);
    run_op("trunc", 10'h010, 10'h001, 10'h000, 1'b0);

    // Extra starts during CALC and DONE must be ignored.
    A = 10'h030;
    B = 10'h040;
    start = 1'b1;
    @(negedge clk);
    A = 10'h3E0;
    B = 10'h3E0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    k = 4;
    while (!valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("ignore_latency", k, 11);
    check("ignore_P", P, 10'h060);
    check("ignore_ovf", ovf, 0);
    start = 1'b1;
    A = 10'h155;
    B = 10'h2AA;
    @(negedge clk);
    start = 1'b0;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      A = 10'($urandom);
      B = 10'($urandom);
      if (valid) vcount++;
      if (busy) vcount++;
      @(negedge clk);
    end
    check("ignore_no_restart", vcount, 0);
    check("ignore_P_stable", P, 10'h060);

    // Reset during the 5th CALC cycle aborts without a valid pulse.
    A = 10'h030;
    B = 10'h040;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_P", P, 0);
    check("abort_ovf", ovf, 0);
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      if (valid) vcount++;
      @(negedge clk);
    end
    check("abort_no_valid", vcount, 0);
    run_op("zero_a", 10'h000, 10'h3FF, 10'h000, 1'b0);

    // start held high: back-to-back operations every 12 cycles.
    A = 10'h030;
    B = 10'h040;
    start = 1'b1;
    vcount = 0;
    k = 0;
    while (vcount < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (valid) begin
        t[vcount] = k;
        vcount++;
      end
    end
    start = 1'b0;
    check("held_pulses", vcount, 3);
    if (vcount == 3) begin
      check("held_spacing_1", t[1] - t[0], 12);
      check("held_spacing_2", t[2] - t[1], 12);
    end
    check("held_P", P, 10'h060);
    k = 0;
    while ((busy || valid) && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("held_drain", busy | valid, 0);
    @(negedge clk);

    // Random regression against sat(floor(A*B/32)).
    for (int i = 0; i < 1000; i++) begin
      ra = 10'($urandom);
      rb = 10'($urandom);
      if (i % 4 == 0) rb = 10'($urandom_range(0, 63));
      m = model(ra, rb);
      run_op("rand", ra, rb, m[9:0], m[10]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
